mem_wait_ctrl: RTL

Parametrised, byte-addressed RAM with the processor's MOV/MOC four-phase memory handshake, programmable wait states, byte/halfword/word access sizes, sign/zero extension, selectable endianness and misalignment detection. It sits beside `data_path` as the memory the control unit's MOV/R_W/size/SE signals drive and whose MOC it waits on. It replaces the fixed-latency, fixed-format memory used in the current system top.

---
 rtl/mem_wait_ctrl_if.sv | 25 ++
 rtl/mem_wait_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mem_wait_ctrl_if.sv
// mem_wait_ctrl bus: MOV/MOC four-phase memory handshake
// plus request fields and read data.
interface mem_wait_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              MOV;
    logic              R_W;
    logic [1:0]        size;
    logic              SE;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data_in;
    logic [31:0]       data_out;
    logic              MOC;
    logic              ERR;

    modport master (
        output MOV, R_W, size, SE, addr, data_in,
        input  data_out, MOC, ERR
    );

    modport slave (
        input  MOV, R_W, size, SE, addr, data_in,
        output data_out, MOC, ERR
    );
endinterface

// File: rtl/mem_wait_ctrl.sv
// mem_wait_ctrl: byte-addressed RAM behind a MOV/MOC handshake
// with wait states, access sizes, extension and endianness.
module mem_wait_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int WAIT       = 2,
    parameter int BIG_ENDIAN = 1
) (
    input logic           clk,
    input logic           clr,
    mem_wait_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE, ST_WAIT, ST_ACCESS, ST_DONE
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              rw_q;
    logic              se_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       din_q;
    logic [31:0]       res_q;
    logic              fault_q;
    logic              upd_q;
    logic              moc_q;
    logic              err_q;
    logic [31:0]       dout_q;

    logic [7:0] mem [2**ADDR_W];

    logic [ADDR_W-1:0] a0, a1, a2, a3;
    logic [7:0]        b0, b1, b2, b3;
    logic [7:0]        w0, w1, w2, w3;
    logic [15:0]       hw;
    logic [31:0]       rd_val;
    logic              fault;
    logic              we;

    assign a0 = addr_q;
    assign a1 = addr_q + ADDR_W'(1);
    assign a2 = addr_q + ADDR_W'(2);
    assign a3 = addr_q + ADDR_W'(3);
    assign b0 = mem[a0];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];

    assign bus.MOC      = moc_q;
    assign bus.ERR      = err_q;
    assign bus.data_out = dout_q;

    // Alignment and size check of the latched request
    always_comb begin
        fault = 1'b0;
        case (size_q)
            2'b00:   fault = 1'b0;
            2'b01:   fault = addr_q[0];
            2'b10:   fault = |addr_q[1:0];
            default: fault = 1'b1;
        endcase
    end

    // Assemble read value from bytes, then extend to 32 bits
    always_comb begin
        hw     = (BIG_ENDIAN != 0) ? {b0, b1} : {b1, b0};
        rd_val = '0;
        case (size_q)
            2'b00:   rd_val = {{24{se_q & b0[7]}}, b0};
            2'b01:   rd_val = {{16{se_q & hw[15]}}, hw};
            default: rd_val = (BIG_ENDIAN != 0) ? {b0, b1, b2, b3}
                                                : {b3, b2, b1, b0};
        endcase
    end

    // Split write data into the bytes landing at addr+0..addr+3
    always_comb begin
        w0 = din_q[7:0];
        w1 = din_q[15:8];
        w2 = din_q[23:16];
        w3 = din_q[31:24];
        if (BIG_ENDIAN != 0) begin
            if (size_q == 2'b01) begin
                w0 = din_q[15:8];
                w1 = din_q[7:0];
            end else if (size_q == 2'b10) begin
                w0 = din_q[31:24];
                w1 = din_q[23:16];
                w2 = din_q[15:8];
                w3 = din_q[7:0];
            end
        end
    end

    assign we = clr && (state == ST_ACCESS) && !fault && !rw_q;

    // Memory array: committed only from a clean ACCESS write, never reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[a0] <= w0;
            if (size_q != 2'b00) begin
                mem[a1] <= w1;
            end
            if (size_q == 2'b10) begin
                mem[a2] <= w2;
                mem[a3] <= w3;
            end
        end
    end

    // Handshake FSM; outputs publish one edge after entering DONE
    always_ff @(posedge clk) begin
        if (!clr) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            rw_q    <= 1'b0;
            se_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            res_q   <= '0;
            fault_q <= 1'b0;
            upd_q   <= 1'b0;
            moc_q   <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    moc_q <= 1'b0;
                    err_q <= 1'b0;
                    if (bus.MOV) begin
                        rw_q   <= bus.R_W;
                        se_q   <= bus.SE;
                        size_q <= bus.size;
                        addr_q <= bus.addr;
                        din_q  <= bus.data_in;
                        if (WAIT == 0) begin
                            state <= ST_ACCESS;
                        end else begin
                            cnt   <= 4'(WAIT - 1);
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= ST_ACCESS;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    fault_q <= fault;
                    res_q   <= fault ? 32'd0 : rd_val;
                    upd_q   <= rw_q | fault;
                    state   <= ST_DONE;
                end
                ST_DONE: begin
                    moc_q <= 1'b1;
                    err_q <= fault_q;
                    if (upd_q) begin
                        dout_q <= res_q;
                        upd_q  <= 1'b0;
                    end
                    if (!bus.MOV) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end
endmodule
